// File: rtl/gate_pkg.sv
// Shared types for the debounced gate unit: the LED reduction operation codes.
package gate_pkg;

  localparam int unsigned OP_W = 3;

  // Codes 6 and 7 are reserved and reduce to 0.
  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5
  } op_e;

endpackage

// File: rtl/switch_debouncer.sv
// One switch bit: 2-flop synchroniser followed by a saturating-count debouncer.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_i,
  output logic stable_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             stable_q;
  logic [CNT_W-1:0] cnt;

  // Synchronise the raw level, then commit it once it has differed from the
  // stable level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      s1 <= sw_i;
      s2 <= s1;
      if (s2 == stable_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable_q <= s2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/debounced_gate_unit.sv
// N debounced switches reduced by a runtime-selected logic op onto one LED.
module debounced_gate_unit
  import gate_pkg::*;
#(
  parameter int N_INPUTS        = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_INPUTS-1:0] sw_i,
  input  op_e                 op_i,
  output logic [N_INPUTS-1:0] sw_stable_o,
  output logic                led_o,
  output logic                led_changed_o
);

  logic result;
  logic led_q;
  logic changed_q;

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_sw
    switch_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw_i    (sw_i[i]),
      .stable_o(sw_stable_o[i])
    );
  end

  // Reduce the debounced levels with the selected operation.
  always_comb begin
    result = 1'b0;
    case (op_i)
      OP_AND:  result = &sw_stable_o;
      OP_OR:   result = |sw_stable_o;
      OP_XOR:  result = ^sw_stable_o;
      OP_NAND: result = ~&sw_stable_o;
      OP_NOR:  result = ~|sw_stable_o;
      OP_XNOR: result = ~^sw_stable_o;
      default: result = 1'b0;
    endcase
  end

  // Register the LED and flag the cycle in which it takes a new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      led_q     <= result;
      changed_q <= (result != led_q);
    end
  end

  assign led_o         = led_q;
  assign led_changed_o = changed_q;

endmodule

// File: tb/tb_debounced_gate_unit.sv
// Directed bench for debounced_gate_unit (3 inputs / 4 cycles, plus 2 inputs / 1 cycle).
module tb_debounced_gate_unit;
  import gate_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [2:0] sw;
  op_e        op;
  logic [2:0] stable;
  logic       led;
  logic       chg;

  logic [1:0] sw2;
  op_e        op2;
  logic [1:0] stable2;
  logic       led2;
  logic       chg2;

  int errors;
  int checks;

  debounced_gate_unit #(
    .N_INPUTS       (3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_i         (sw),
    .op_i         (op),
    .sw_stable_o  (stable),
    .led_o        (led),
    .led_changed_o(chg)
  );

  debounced_gate_unit #(
    .N_INPUTS       (2),
    .DEBOUNCE_CYCLES(1)
  ) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_i         (sw2),
    .op_i         (op2),
    .sw_stable_o  (stable2),
    .led_o        (led2),
    .led_changed_o(chg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic       sweep_led [8];
  logic       sweep_chg [8];

  initial begin
    errors = 0;
    checks = 0;
    sweep_led = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    sweep_chg = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // 1: reset with switches high, then release with AND
    rst_n = 1'b0;
    sw    = 3'b111;
    op    = OP_AND;
    sw2   = 2'b00;
    op2   = OP_AND;
    tick(3);
    check("rst_led", led, 0);
    check("rst_stable", stable, 0);
    check("rst_chg", chg, 0);
    rst_n = 1'b1;
    tick(5);
    check("t1_stable_k4", stable, 3'b000);
    tick(1);
    check("t1_stable_k5", stable, 3'b111);
    check("t1_led_k5", led, 0);
    tick(1);
    check("t1_led_k6", led, 1);
    check("t1_chg_k6", chg, 1);
    tick(1);
    check("t1_chg_k7", chg, 0);
    check("t1_led_k7", led, 1);

    // 2: 2-cycle glitch on bit 2 never commits
    sw = 3'b011;
    tick(2);
    sw = 3'b111;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("t2_stable", stable, 3'b111);
      check("t2_led", led, 1);
      check("t2_chg", chg, 0);
    end

    // 3: op sweep over stable 101
    sw = 3'b101;
    tick(8);
    check("t3_stable", stable, 3'b101);
    check("t3_led_pre", led, 0);
    for (int i = 0; i < 8; i++) begin
      op = op_e'(i[2:0]);
      tick(1);
      check($sformatf("t3_led_op%0d", i), led, sweep_led[i]);
      check($sformatf("t3_chg_op%0d", i), chg, sweep_chg[i]);
      tick(2);
    end

    // 4: XOR, single bit rises
    op = OP_XOR;
    sw = 3'b000;
    tick(10);
    check("t4_led_pre", led, 0);
    check("t4_stable_pre", stable, 3'b000);
    sw = 3'b001;
    tick(5);
    check("t4_stable_k4", stable, 3'b000);
    tick(1);
    check("t4_stable_k5", stable, 3'b001);
    check("t4_led_k5", led, 0);
    tick(1);
    check("t4_led_k6", led, 1);
    check("t4_chg_k6", chg, 1);
    tick(1);
    check("t4_chg_k7", chg, 0);

    // 5: reset while bits 1,2 are mid-debounce (counter == 2)
    sw = 3'b111;
    tick(4);
    check("t5_stable_mid", stable, 3'b001);
    check("t5_led_mid", led, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_stable", stable, 0);
    check("t5_rst_led", led, 0);
    check("t5_rst_chg", chg, 0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("t5_stable_k4", stable, 3'b000);
    check("t5_led_k4", led, 0);
    tick(1);
    check("t5_stable_k5", stable, 3'b111);
    check("t5_led_k5", led, 0);
    tick(1);
    check("t5_led_k6", led, 1);
    check("t5_chg_k6", chg, 1);

    // 6: 2-input AND with 1-cycle debounce truth table
    for (int i = 0; i < 4; i++) begin
      sw2 = i[1:0];
      tick(3);
      check($sformatf("t6_stable_%0d", i), stable2, i[1:0]);
      check($sformatf("t6_led_old_%0d", i), led2, 0);
      tick(1);
      check($sformatf("t6_led_%0d", i), led2, (i == 3) ? 1 : 0);
      tick(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
